stage1_multi: RTL and testbench

- Parametrised successor to the single-leg L/M/N stage of the ball-and-plate inverse kinematics.
- For each of NUM_LEGS servo legs, computes the servo-equation terms:
  - L = lx²+ly²+lz² − K
  - M = 2A·lz
  - N = 2A·(cosβ·lx + sinβ·ly)
- All legs are captured from one enable pulse. Legs are processed sequentially through one shared multiplier.
- Per-leg results go out on a valid/ready stream to the angle-solving stage.

---
 rtl/stage1_multi.sv | 160 ++++++++++++++++
 tb/tb_stage1_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_multi.sv
// L/M/N servo-term stage for NUM_LEGS legs, sequenced through one shared signed multiplier.
// Latency: leg k is presented 6 + 7k cycles after the accepted enable, when out_ready is held high.
// Backpressure: each result is held in EMIT until out_ready is high; enable is ignored while busy.
module stage1_multi #(
    parameter int NUM_LEGS = 3,
    parameter int IN_W     = 9,
    parameter int A        = 25,
    parameter int A_W      = 8,
    parameter int K        = 13775,
    parameter int COEF_W   = 16,
    parameter logic [NUM_LEGS*COEF_W-1:0] COS_LIST = {-16'sd14189, 16'sd0, 16'sd14189},
    parameter logic [NUM_LEGS*COEF_W-1:0] SIN_LIST = {-16'sd8192, 16'sd16384, -16'sd8192},
    parameter int N_W      = 15
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_LEGS*IN_W-1:0]      lx_bus,
    input  logic [NUM_LEGS*IN_W-1:0]      ly_bus,
    input  logic [NUM_LEGS*(IN_W-1)-1:0]  lz_bus,
    input  logic                          out_ready,
    output logic                          busy,
    output logic signed [2*IN_W+1:0]      L,
    output logic [IN_W+A_W-1:0]           M,
    output logic signed [N_W-1:0]         N,
    output logic [2:0]                    out_leg,
    output logic                          valid,
    output logic                          n_sat,
    output logic                          done
);
    localparam int ACC_W = 2*IN_W + 2;
    localparam int M_W   = IN_W + A_W;
    localparam int P_W   = COEF_W + IN_W + 1;
    localparam int PR_W  = (P_W > ACC_W) ? P_W : ACC_W;
    localparam int T_W   = PR_W + A_W + 2;

    localparam logic signed [PR_W-1:0] K_T      = PR_W'(K);
    localparam logic signed [T_W-1:0]  TWO_A_T  = T_W'(2*A);
    localparam logic [M_W-1:0]         TWO_A_M  = M_W'(2*A);
    localparam logic signed [T_W-1:0]  RND_T    = T_W'(2**(COEF_W-3));
    localparam logic signed [T_W-1:0]  N_MAX_T  = T_W'(2**(N_W-1) - 1);
    localparam logic signed [T_W-1:0]  N_MIN_T  = -N_MAX_T - T_W'(1);
    localparam logic [2:0]             LAST_LEG = 3'(NUM_LEGS-1);

    typedef enum logic [2:0] {IDLE, SX, SY, SZ, PC, PS, EMIT} state_t;

    state_t                       state;
    logic [2:0]                   leg;
    logic [NUM_LEGS*IN_W-1:0]     lx_r, ly_r;
    logic [NUM_LEGS*(IN_W-1)-1:0] lz_r;
    logic signed [PR_W-1:0]       acc, p;

    logic signed [IN_W-1:0]   cur_lx, cur_ly;
    logic [IN_W-2:0]          cur_lz;
    logic signed [COEF_W-1:0] cur_cos, cur_sin;
    logic signed [PR_W-1:0]   op_a, op_b, prod, l_full;
    logic signed [T_W-1:0]    scaled, nraw;
    logic signed [N_W-1:0]    n_next;
    logic                     sat_next;
    logic [M_W-1:0]           m_next;

    always_comb begin
        cur_lx  = lx_r[leg*IN_W +: IN_W];
        cur_ly  = ly_r[leg*IN_W +: IN_W];
        cur_lz  = lz_r[leg*(IN_W-1) +: (IN_W-1)];
        cur_cos = COS_LIST[leg*COEF_W +: COEF_W];
        cur_sin = SIN_LIST[leg*COEF_W +: COEF_W];
    end

    // Operand steering for the single shared multiplier.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            SX:      begin op_a = PR_W'(cur_lx);  op_b = PR_W'(cur_lx); end
            SY:      begin op_a = PR_W'(cur_ly);  op_b = PR_W'(cur_ly); end
            SZ:      begin op_a = PR_W'(cur_lz);  op_b = PR_W'(cur_lz); end
            PC:      begin op_a = PR_W'(cur_cos); op_b = PR_W'(cur_lx); end
            PS:      begin op_a = PR_W'(cur_sin); op_b = PR_W'(cur_ly); end
            default: begin op_a = '0;             op_b = '0;            end
        endcase
        prod = op_a * op_b;
    end

    // Round half up, then clamp to the N_W signed range.
    always_comb begin
        l_full   = acc - K_T;
        m_next   = M_W'(cur_lz) * TWO_A_M;
        scaled   = T_W'(p) * TWO_A_T + RND_T;
        nraw     = scaled >>> (COEF_W-2);
        sat_next = 1'b0;
        n_next   = nraw[N_W-1:0];
        if (nraw > N_MAX_T) begin
            n_next   = N_MAX_T[N_W-1:0];
            sat_next = 1'b1;
        end else if (nraw < N_MIN_T) begin
            n_next   = N_MIN_T[N_W-1:0];
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            leg     <= '0;
            lx_r    <= '0;
            ly_r    <= '0;
            lz_r    <= '0;
            acc     <= '0;
            p       <= '0;
            busy    <= 1'b0;
            L       <= '0;
            M       <= '0;
            N       <= '0;
            out_leg <= '0;
            valid   <= 1'b0;
            n_sat   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    lx_r  <= lx_bus;
                    ly_r  <= ly_bus;
                    lz_r  <= lz_bus;
                    leg   <= '0;
                    busy  <= 1'b1;
                    state <= SX;
                end
                SX: begin acc <= prod;       state <= SY;   end
                SY: begin acc <= acc + prod; state <= SZ;   end
                SZ: begin acc <= acc + prod; state <= PC;   end
                PC: begin p   <= prod;       state <= PS;   end
                PS: begin p   <= p + prod;   state <= EMIT; end
                EMIT: begin
                    // First EMIT cycle registers the result; later cycles wait for the handshake.
                    if (!valid) begin
                        L       <= l_full[ACC_W-1:0];
                        M       <= m_next;
                        N       <= n_next;
                        n_sat   <= sat_next;
                        out_leg <= leg;
                        valid   <= 1'b1;
                    end else if (out_ready) begin
                        valid <= 1'b0;
                        if (leg == LAST_LEG) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            leg   <= leg + 3'd1;
                            state <= SX;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stage1_multi.sv
// Directed-vector bench for stage1_multi: default 3-leg instance plus a 1-leg saturation instance (A=40).
module tb_stage1_multi;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst;

    logic               enable, out_ready, busy, valid, n_sat, done;
    logic [26:0]        lx_bus, ly_bus;
    logic [23:0]        lz_bus;
    logic signed [19:0] L;
    logic [16:0]        M;
    logic signed [14:0] N;
    logic [2:0]         out_leg;

    logic               s_enable, s_out_ready, s_busy, s_valid, s_n_sat, s_done;
    logic [8:0]         s_lx_bus, s_ly_bus;
    logic [7:0]         s_lz_bus;
    logic signed [19:0] s_L;
    logic [16:0]        s_M;
    logic signed [14:0] s_N;
    logic [2:0]         s_out_leg;

    stage1_multi dut (
        .clock(clock), .rst(rst), .enable(enable),
        .lx_bus(lx_bus), .ly_bus(ly_bus), .lz_bus(lz_bus),
        .out_ready(out_ready), .busy(busy), .L(L), .M(M), .N(N),
        .out_leg(out_leg), .valid(valid), .n_sat(n_sat), .done(done)
    );

    stage1_multi #(
        .NUM_LEGS(1), .A(40), .COS_LIST(16'sd16384), .SIN_LIST(16'sd0)
    ) sat_dut (
        .clock(clock), .rst(rst), .enable(s_enable),
        .lx_bus(s_lx_bus), .ly_bus(s_ly_bus), .lz_bus(s_lz_bus),
        .out_ready(s_out_ready), .busy(s_busy), .L(s_L), .M(s_M), .N(s_N),
        .out_leg(s_out_leg), .valid(s_valid), .n_sat(s_n_sat), .done(s_done)
    );

    typedef struct {
        bit               sat;
        logic signed [8:0] lx;
        logic signed [8:0] ly;
        logic [7:0]       lz;
        int               l;
        int               m;
        int               n0;
        int               n1;
        int               n2;
        logic [2:0]       s;
    } vec_t;

    vec_t vt [7];
    vec_t cv;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic int exp_n(input int k);
        return (k == 0) ? cv.n0 : (k == 1) ? cv.n1 : cv.n2;
    endfunction

    task automatic start_main();
        lx_bus = {3{cv.lx}};
        ly_bus = {3{cv.ly}};
        lz_bus = {3{cv.lz}};
        enable = 1'b1;
        tick();
        enable = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_leg(input int k, input int exp_cyc);
        int budget;
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!valid && budget < 40);
        chk("leg_valid", valid, 1);
        chk("leg_time", cyc, exp_cyc);
        chk("out_leg", out_leg, k);
        chk("L", L, cv.l);
        chk("M", M, cv.m);
        chk("N", N, exp_n(k));
        chk("n_sat", n_sat, cv.s[k]);
    endtask

    task automatic check_done();
        tick();
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", valid, 0);
        tick();
        chk("done_pulse", done, 0);
    endtask

    task automatic run_sat();
        s_lx_bus = cv.lx;
        s_ly_bus = cv.ly;
        s_lz_bus = cv.lz;
        s_enable = 1'b1;
        tick();
        s_enable = 1'b0;
        cyc = 0;
        do tick(); while (!s_valid && cyc < 40);
        chk("s_time", cyc, 6);
        chk("s_L", s_L, cv.l);
        chk("s_M", s_M, cv.m);
        chk("s_N", s_N, cv.n0);
        chk("s_n_sat", s_n_sat, cv.s[0]);
        tick();
        chk("s_done", s_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, -9'sd24, 9'sd26, 8'd117, 1166, 5850, -1689, 1300, 389, 3'b000};
        vt[1] = '{1'b0, 9'sd0, 9'sd0, 8'd0, -13775, 0, 0, 0, 0, 3'b000};
        vt[2] = '{1'b0, 9'sd100, 9'sd0, 8'd50, -1275, 2500, 4330, 0, -4330, 3'b000};
        vt[3] = '{1'b0, 9'h100, 9'sd255, 8'd255, 181811, 12750, -16384, 12750, 4710, 3'b001};
        vt[4] = '{1'b1, 9'sd255, 9'sd0, 8'd0, 51250, 0, 16383, 0, 0, 3'b001};
        vt[5] = '{1'b1, 9'h100, 9'sd0, 8'd0, 51761, 0, -16384, 0, 0, 3'b001};
        vt[6] = '{1'b1, 9'sd100, 9'sd0, 8'd10, -3675, 800, 8000, 0, 0, 3'b000};

        rst = 1'b0; enable = 1'b0; out_ready = 1'b1;
        lx_bus = '0; ly_bus = '0; lz_bus = '0;
        s_enable = 1'b0; s_out_ready = 1'b1;
        s_lx_bus = '0; s_ly_bus = '0; s_lz_bus = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_L", L, 0);
        chk("rst_M", M, 0);
        chk("rst_N", N, 0);
        chk("rst_leg", out_leg, 0);
        chk("rst_nsat", n_sat, 0);
        @(negedge clock);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            cv = vt[i];
            if (!cv.sat) begin
                start_main();
                chk("busy_start", busy, 1);
                for (int k = 0; k < 3; k++) wait_leg(k, 6 + 7*k);
                check_done();
            end else begin
                run_sat();
            end
            tick();
        end

        // Backpressure on leg0 for five cycles.
        cv = vt[0];
        start_main();
        wait_leg(0, 6);
        out_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("bp_valid", valid, 1);
            chk("bp_N", N, cv.n0);
            chk("bp_L", L, cv.l);
            chk("bp_leg", out_leg, 0);
        end
        out_ready = 1'b1;
        wait_leg(1, 18);
        wait_leg(2, 25);
        check_done();

        // Enable held while busy and inputs changed mid-batch; enable at the done edge is ignored.
        cv = vt[0];
        start_main();
        repeat (3) tick();
        enable = 1'b1;
        lx_bus = {3{9'sd5}};
        ly_bus = {3{9'sd7}};
        lz_bus = {3{8'd9}};
        wait_leg(0, 6);
        wait_leg(1, 13);
        wait_leg(2, 20);
        tick();
        chk("ign_done", done, 1);
        chk("ign_busy", busy, 0);
        enable = 1'b0;
        tick();
        chk("ign_norestart", busy, 0);
        chk("ign_valid", valid, 0);
        chk("ign_done_pulse", done, 0);

        // Asynchronous reset while leg1 is in PC.
        cv = vt[0];
        start_main();
        wait_leg(0, 6);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_valid", valid, 0);
        chk("mid_L", L, 0);
        chk("mid_M", M, 0);
        chk("mid_N", N, 0);
        chk("mid_leg", out_leg, 0);
        chk("mid_done", done, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        repeat (8) begin
            tick();
            chk("post_rst_done", done, 0);
            chk("post_rst_valid", valid, 0);
        end
        start_main();
        for (int k = 0; k < 3; k++) wait_leg(k, 6 + 7*k);
        check_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
